// File: rtl/lsq_ret_pkg.sv
// lsq_ret_pkg: shared constants and the queue entry type for lsq_retire_queue.
//   Default parameter values for the queue and its slot decoder, plus the
//   packed entry that holds one decoded bundle while it waits to retire.
//   The shared payload width comes from the LSQSHARE_WIDTH macro; it falls
//   back to 8 bits when the build does not define it.

`ifndef LSQSHARE_WIDTH
`define LSQSHARE_WIDTH 8
`endif

package lsq_ret_pkg;

  localparam int LSQ_LANES  = 6;
  localparam int LSQ_SLOTS  = 10;
  localparam int LSQ_SLOT_W = 4;
  localparam int LSQ_II_W   = 6;
  localparam int LSQ_EXB_W  = 4;
  localparam int LSQ_SHR_W  = `LSQSHARE_WIDTH;
  localparam int LSQ_DEPTH  = 4;

  // One queued retire group, already decoded into per-slot vectors.
  // Field widths track the package defaults above.
  typedef struct packed {
    logic                            kill;
    logic                            thread;
    logic [LSQ_II_W-1:0]             ii;
    logic [LSQ_SHR_W-1:0]            shr;
    logic [LSQ_SLOTS*LSQ_EXB_W-1:0]  exbits;
    logic [LSQ_SLOTS-1:0]            wtc;
    logic [LSQ_SLOTS-1:0]            ldc;
    logic [LSQ_SLOTS-1:0]            exc;
    logic [LSQ_SLOTS-1:0]            en;
  } lsq_ret_entry_t;

endpackage

// File: rtl/lsq_ret_slot_decode.sv
// lsq_ret_slot_decode: combinational lane-to-slot decode for one bundle.
//   Inputs : ret_mask, slot (packed per lane), excpt/ld_confl/wait_confl,
//            exbits (packed per lane).
//   Outputs: en/exc/ldc/wtc per slot, exbits_o per slot, dup_o.
//   Lanes pointing at a slot index >= SLOTS are ignored.
//   Build option LSQ_RET_DUPCHK_EN: two retiring lanes on one slot raise
//   dup_o and force that slot's exc bit. Without it, lanes on a shared slot
//   are OR-merged and dup_o is 0.

module lsq_ret_slot_decode
  import lsq_ret_pkg::*;
#(
  parameter int LANES  = LSQ_LANES,
  parameter int SLOTS  = LSQ_SLOTS,
  parameter int SLOT_W = LSQ_SLOT_W,
  parameter int EXB_W  = LSQ_EXB_W
) (
  input  logic [LANES-1:0]        ret_mask,
  input  logic [LANES*SLOT_W-1:0] slot,
  input  logic [LANES-1:0]        excpt,
  input  logic [LANES-1:0]        ld_confl,
  input  logic [LANES-1:0]        wait_confl,
  input  logic [LANES*EXB_W-1:0]  exbits,
  output logic [SLOTS-1:0]        en_o,
  output logic [SLOTS-1:0]        exc_o,
  output logic [SLOTS-1:0]        ldc_o,
  output logic [SLOTS-1:0]        wtc_o,
  output logic [SLOTS*EXB_W-1:0]  exbits_o,
  output logic                    dup_o
);

`ifdef LSQ_RET_DUPCHK_EN
  logic [SLOTS-1:0] dup_slot;
`endif

  always_comb begin
    en_o     = '0;
    exc_o    = '0;
    ldc_o    = '0;
    wtc_o    = '0;
    exbits_o = '0;
    dup_o    = 1'b0;
`ifdef LSQ_RET_DUPCHK_EN
    dup_slot = '0;
`endif
    for (int k = 0; k < SLOTS; k++) begin
      for (int l = 0; l < LANES; l++) begin
        if (ret_mask[l] && (slot[l*SLOT_W +: SLOT_W] == SLOT_W'(k))) begin
`ifdef LSQ_RET_DUPCHK_EN
          // en_o[k] already set means an earlier lane claimed this slot
          if (en_o[k]) dup_slot[k] = 1'b1;
`endif
          en_o[k]  = 1'b1;
          exc_o[k] = exc_o[k] | excpt[l];
          ldc_o[k] = ldc_o[k] | ld_confl[l];
          wtc_o[k] = wtc_o[k] | wait_confl[l];
          exbits_o[k*EXB_W +: EXB_W] = exbits_o[k*EXB_W +: EXB_W] |
                                       exbits[l*EXB_W +: EXB_W];
        end
      end
    end
`ifdef LSQ_RET_DUPCHK_EN
    exc_o = exc_o | dup_slot;
    dup_o = |dup_slot;
`endif
  end

endmodule

// File: rtl/lsq_retire_queue.sv
// lsq_retire_queue: in-order retire decision queue between the LSQ
// disambiguate/align stage and the retire control unit.
//   clk/rst       : rising-edge clock, asynchronous active-low reset (rst).
//   in_*          : bundle enqueue (valid/ready handshake), decoded at entry.
//   cntrl_II, doRetire, bStall : retire request for the head group.
//   except, except_thread      : kill every queued entry of one thread.
//   out_valid/out_II/deq       : live head and combinational pop strobe.
//   retire_*      : registered one-cycle retire results, zero otherwise.
//   dup_err       : sticky slot-collision flag (LSQ_RET_DUPCHK_EN builds).

module lsq_retire_queue
  import lsq_ret_pkg::*;
#(
  parameter int LANES  = LSQ_LANES,
  parameter int SLOTS  = LSQ_SLOTS,
  parameter int SLOT_W = LSQ_SLOT_W,
  parameter int II_W   = LSQ_II_W,
  parameter int EXB_W  = LSQ_EXB_W,
  parameter int SHR_W  = LSQ_SHR_W,
  parameter int DEPTH  = LSQ_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_thread,
  input  logic [II_W-1:0]         in_II,
  input  logic [LANES-1:0]        in_ret_mask,
  input  logic [LANES*SLOT_W-1:0] in_slot,
  input  logic [LANES-1:0]        in_excpt,
  input  logic [LANES-1:0]        in_ld_confl,
  input  logic [LANES-1:0]        in_wait_confl,
  input  logic [LANES*EXB_W-1:0]  in_exbits,
  input  logic [SHR_W-1:0]        in_shr,
  input  logic [II_W-1:0]         cntrl_II,
  input  logic                    doRetire,
  input  logic                    bStall,
  input  logic                    except,
  input  logic                    except_thread,
  output logic                    out_valid,
  output logic [II_W-1:0]         out_II,
  output logic                    deq,
  output logic [SLOTS-1:0]        retire_enOut,
  output logic [SLOTS-1:0]        retire_fine,
  output logic [SLOTS-1:0]        retire_ldconfl,
  output logic [SLOTS-1:0]        retire_waitconfl,
  output logic [SLOTS-1:0]        retire_except,
  output logic [SLOTS*EXB_W-1:0]  retire_exbits,
  output logic [SHR_W-1:0]        retire_shr,
  output logic                    retire_thread,
  output logic                    dup_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lsq_ret_entry_t mem_q [DEPTH];
  lsq_ret_entry_t mem_d [DEPTH];
  lsq_ret_entry_t head;
  lsq_ret_entry_t new_entry;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [SLOTS-1:0]       dec_en, dec_exc, dec_ldc, dec_wtc;
  logic [SLOTS*EXB_W-1:0] dec_exbits;
  logic                   dec_dup;

  logic [SLOTS-1:0]       retire_en_q, retire_en_d;
  logic [SLOTS-1:0]       retire_fine_q, retire_fine_d;
  logic [SLOTS-1:0]       retire_ldc_q, retire_ldc_d;
  logic [SLOTS-1:0]       retire_wtc_q, retire_wtc_d;
  logic [SLOTS-1:0]       retire_exc_q, retire_exc_d;
  logic [SLOTS*EXB_W-1:0] retire_exbits_q, retire_exbits_d;
  logic [SHR_W-1:0]       retire_shr_q, retire_shr_d;
  logic                   retire_thread_q, retire_thread_d;
  logic                   dup_err_q, dup_err_d;

  logic head_present, flush_head, drop, pop, push;

  lsq_ret_slot_decode #(
    .LANES  (LANES),
    .SLOTS  (SLOTS),
    .SLOT_W (SLOT_W),
    .EXB_W  (EXB_W)
  ) u_decode (
    .ret_mask   (in_ret_mask),
    .slot       (in_slot),
    .excpt      (in_excpt),
    .ld_confl   (in_ld_confl),
    .wait_confl (in_wait_confl),
    .exbits     (in_exbits),
    .en_o       (dec_en),
    .exc_o      (dec_exc),
    .ldc_o      (dec_ldc),
    .wtc_o      (dec_wtc),
    .exbits_o   (dec_exbits),
    .dup_o      (dec_dup)
  );

  always_comb begin
    new_entry        = '0;
    new_entry.kill   = 1'b0;
    new_entry.thread = in_thread;
    new_entry.ii     = in_II;
    new_entry.shr    = in_shr;
    new_entry.exbits = dec_exbits;
    new_entry.wtc    = dec_wtc;
    new_entry.ldc    = dec_ldc;
    new_entry.exc    = dec_exc;
    new_entry.en     = dec_en;
  end

  always_comb begin
    head         = mem_q[rd_ptr_q];
    head_present = (count_q != '0);
    out_valid    = head_present & ~head.kill;
    out_II       = out_valid ? head.ii : '0;
    in_ready     = (count_q < CNT_W'(DEPTH));

    // a flush of the head's own thread wins over a retire in the same cycle
    flush_head = except & (except_thread == head.thread);
    deq  = out_valid & doRetire & ~bStall & (cntrl_II == head.ii) & ~flush_head;
    drop = head_present & head.kill;
    pop  = deq | drop;
    // a push of the thread being flushed is swallowed, never stored
    push = in_valid & in_ready & ~(except & (except_thread == in_thread));

    // kill bits on stale slots are harmless: enqueue rewrites the whole entry
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (except && (mem_q[i].thread == except_thread)) mem_d[i].kill = 1'b1;
    end
    if (push) mem_d[wr_ptr_q] = new_entry;

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    retire_en_d     = '0;
    retire_fine_d   = '0;
    retire_ldc_d    = '0;
    retire_wtc_d    = '0;
    retire_exc_d    = '0;
    retire_exbits_d = '0;
    retire_shr_d    = '0;
    retire_thread_d = 1'b0;
    if (deq) begin
      retire_en_d     = head.en;
      retire_fine_d   = head.en & ~head.exc & ~head.ldc & ~head.wtc;
      retire_ldc_d    = head.ldc;
      retire_wtc_d    = head.wtc;
      retire_exc_d    = head.exc;
      retire_exbits_d = head.exbits;
      retire_shr_d    = head.shr;
      retire_thread_d = head.thread;
    end

    dup_err_d = dup_err_q | (push & dec_dup);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      retire_en_q     <= '0;
      retire_fine_q   <= '0;
      retire_ldc_q    <= '0;
      retire_wtc_q    <= '0;
      retire_exc_q    <= '0;
      retire_exbits_q <= '0;
      retire_shr_q    <= '0;
      retire_thread_q <= 1'b0;
      dup_err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      retire_en_q     <= retire_en_d;
      retire_fine_q   <= retire_fine_d;
      retire_ldc_q    <= retire_ldc_d;
      retire_wtc_q    <= retire_wtc_d;
      retire_exc_q    <= retire_exc_d;
      retire_exbits_q <= retire_exbits_d;
      retire_shr_q    <= retire_shr_d;
      retire_thread_q <= retire_thread_d;
      dup_err_q       <= dup_err_d;
    end
  end

  assign retire_enOut     = retire_en_q;
  assign retire_fine      = retire_fine_q;
  assign retire_ldconfl   = retire_ldc_q;
  assign retire_waitconfl = retire_wtc_q;
  assign retire_except    = retire_exc_q;
  assign retire_exbits    = retire_exbits_q;
  assign retire_shr       = retire_shr_q;
  assign retire_thread    = retire_thread_q;
  assign dup_err          = dup_err_q;

endmodule

// File: tb/tb_lsq_retire_queue.sv
// Randomised + directed bench for lsq_retire_queue with a queue-based
// reference model and a negedge monitor that compares retire results.

module tb_lsq_retire_queue;
  import lsq_ret_pkg::*;

  localparam int L  = 6;
  localparam int S  = 10;
  localparam int SW = 4;
  localparam int IW = 6;
  localparam int EW = 4;
  localparam int HW = LSQ_SHR_W;
`ifdef LSQ_RET_DUPCHK_EN
  localparam bit DUP_ON = 1'b1;
`else
  localparam bit DUP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, in_thread;
  logic [IW-1:0] in_II;
  logic [L-1:0]  in_ret_mask, in_excpt, in_ld_confl, in_wait_confl;
  logic [L*SW-1:0] in_slot;
  logic [L*EW-1:0] in_exbits;
  logic [HW-1:0] in_shr;
  logic [IW-1:0] cntrl_II;
  logic          doRetire, bStall, except, except_thread;
  logic          out_valid, deq;
  logic [IW-1:0] out_II;
  logic [S-1:0]  retire_enOut, retire_fine, retire_ldconfl, retire_waitconfl, retire_except;
  logic [S*EW-1:0] retire_exbits;
  logic [HW-1:0] retire_shr;
  logic          retire_thread, dup_err;

  lsq_retire_queue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_thread(in_thread), .in_II(in_II),
    .in_ret_mask(in_ret_mask), .in_slot(in_slot), .in_excpt(in_excpt),
    .in_ld_confl(in_ld_confl), .in_wait_confl(in_wait_confl), .in_exbits(in_exbits),
    .in_shr(in_shr), .cntrl_II(cntrl_II), .doRetire(doRetire), .bStall(bStall),
    .except(except), .except_thread(except_thread),
    .out_valid(out_valid), .out_II(out_II), .deq(deq),
    .retire_enOut(retire_enOut), .retire_fine(retire_fine),
    .retire_ldconfl(retire_ldconfl), .retire_waitconfl(retire_waitconfl),
    .retire_except(retire_except), .retire_exbits(retire_exbits),
    .retire_shr(retire_shr), .retire_thread(retire_thread), .dup_err(dup_err)
  );

  typedef struct {
    logic [S-1:0]    en, exc, ldc, wtc;
    logic [S*EW-1:0] exb;
    logic [IW-1:0]   ii;
    logic            thr;
    logic [HW-1:0]   shr;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  bit   pend_v  = 1'b0;
  bit   exp_dup = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  bit   cap_acc, cap_fl, cap_flt, cap_dup;
  exp_t cap_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode: each retiring lane with an in-range slot contributes to it.
  function automatic exp_t model_bundle(output bit dup);
    exp_t e;
    int   cnt[S];
    int   s;
    e = '{default: '0};
    e.ii  = in_II;
    e.thr = in_thread;
    e.shr = in_shr;
    for (int k = 0; k < S; k++) cnt[k] = 0;
    for (int l = 0; l < L; l++) begin
      s = int'(in_slot[l*SW +: SW]);
      if (in_ret_mask[l] && s < S) begin
        cnt[s]++;
        e.en[s] = 1'b1;
        if (in_excpt[l])      e.exc[s] = 1'b1;
        if (in_ld_confl[l])   e.ldc[s] = 1'b1;
        if (in_wait_confl[l]) e.wtc[s] = 1'b1;
        e.exb[s*EW +: EW] = e.exb[s*EW +: EW] | in_exbits[l*EW +: EW];
      end
    end
    dup = 1'b0;
    if (DUP_ON) begin
      for (int k = 0; k < S; k++) begin
        if (cnt[k] > 1) begin
          e.exc[k] = 1'b1;
          dup = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic half();
    @(negedge clk);
    cap_acc = in_valid && in_ready && !(except && (except_thread == in_thread));
    cap_fl  = except;
    cap_flt = except_thread;
    cap_e   = model_bundle(cap_dup);
  endtask

  task automatic fin();
    exp_t keep[$];
    @(posedge clk);
    if (cap_fl) begin
      foreach (sb[i]) if (sb[i].thr != cap_flt) keep.push_back(sb[i]);
      sb = keep;
    end
    if (cap_acc) begin
      sb.push_back(cap_e);
      if (cap_dup) exp_dup = 1'b1;
    end
    #1;
  endtask

  task automatic step();
    half();
    fin();
  endtask

  task automatic clear_bundle();
    in_valid = 1'b0; in_thread = 1'b0; in_II = '0; in_ret_mask = '0; in_slot = '0;
    in_excpt = '0; in_ld_confl = '0; in_wait_confl = '0; in_exbits = '0; in_shr = '0;
  endtask

  task automatic set_lane(input int l, input int s, input bit e, input bit ld,
                          input bit w, input logic [EW-1:0] xb);
    in_ret_mask[l]        = 1'b1;
    in_slot[l*SW +: SW]   = SW'(s);
    in_excpt[l]           = e;
    in_ld_confl[l]        = ld;
    in_wait_confl[l]      = w;
    in_exbits[l*EW +: EW] = xb;
  endtask

  task automatic rand_bundle();
    in_thread     = 1'($urandom);
    in_II         = IW'($urandom);
    in_ret_mask   = L'($urandom);
    in_slot       = (L*SW)'($urandom);
    in_excpt      = L'($urandom & $urandom);
    in_ld_confl   = L'($urandom & $urandom);
    in_wait_confl = L'($urandom & $urandom);
    in_exbits     = (L*EW)'($urandom);
    in_shr        = HW'($urandom);
  endtask

  task automatic drain(input int budget, input string name);
    in_valid = 1'b0; except = 1'b0; bStall = 1'b0;
    for (int i = 0; i < budget && sb.size() > 0; i++) begin
      doRetire = 1'b1;
      cntrl_II = sb[0].ii;
      step();
    end
    doRetire = 1'b0;
    repeat (4) step();
    chk(name, 64'(sb.size()), 64'(0));
  endtask

  // Monitor: a deq seen in one cycle must show up on retire_* in the next.
  always @(negedge clk) begin
    if (!rst) begin
      pend_v = 1'b0;
    end else begin
      if (pend_v) begin
        chk("ret_en",     64'(retire_enOut),     64'(pend.en));
        chk("ret_fine",   64'(retire_fine),      64'(pend.en & ~pend.exc & ~pend.ldc & ~pend.wtc));
        chk("ret_ldc",    64'(retire_ldconfl),   64'(pend.ldc));
        chk("ret_wtc",    64'(retire_waitconfl), 64'(pend.wtc));
        chk("ret_exc",    64'(retire_except),    64'(pend.exc));
        chk("ret_exbits", 64'(retire_exbits),    64'(pend.exb));
        chk("ret_shr",    64'(retire_shr),       64'(pend.shr));
        chk("ret_thread", 64'(retire_thread),    64'(pend.thr));
      end else begin
        chk("ret_idle", 64'(|{retire_enOut, retire_fine, retire_ldconfl, retire_waitconfl,
                             retire_except, retire_exbits, retire_shr, retire_thread}), 64'(0));
      end
      chk("dup_err", 64'(dup_err), 64'(exp_dup));
      pend_v = deq;
      if (deq) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deq_unexpected: got deq=1 expected no live entry");
          pend_v = 1'b0;
        end else begin
          pend = sb.pop_front();
          chk("out_II", 64'(out_II), 64'(pend.ii));
        end
      end
    end
  end

  initial begin
    clear_bundle();
    cntrl_II = '0; doRetire = 1'b0; bStall = 1'b0; except = 1'b0; except_thread = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // reset state
    half();
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_deq",       64'(deq),       64'(0));
    chk("rst_dup",       64'(dup_err),   64'(0));
    chk("rst_en",        64'(retire_enOut), 64'(0));
    fin();

    // single bundle, slots 3 and 7 (7 with load conflict)
    clear_bundle();
    in_valid = 1'b1; in_II = 6'd5;
    set_lane(0, 3, 1'b0, 1'b0, 1'b0, 4'h0);
    set_lane(2, 7, 1'b0, 1'b1, 1'b0, 4'h0);
    step();
    clear_bundle();
    doRetire = 1'b1; cntrl_II = 6'd5;
    half();
    chk("single_deq", 64'(deq), 64'(1));
    fin();
    doRetire = 1'b0;
    half();
    chk("single_en",   64'(retire_enOut),   64'(10'h088));
    chk("single_fine", 64'(retire_fine),    64'(10'h008));
    chk("single_ldc",  64'(retire_ldconfl), 64'(10'h080));
    fin();
    half();
    chk("single_pulse", 64'(retire_enOut), 64'(0));
    fin();

    // fill to depth, fifth push waits for a pop
    for (int i = 0; i < 4; i++) begin
      rand_bundle(); in_thread = 1'b0; in_II = IW'(10 + i); in_valid = 1'b1;
      step();
    end
    rand_bundle(); in_thread = 1'b0; in_II = 6'd20; in_valid = 1'b1;
    half();
    chk("full_ready", 64'(in_ready), 64'(0));
    fin();
    doRetire = 1'b1; cntrl_II = sb[0].ii;
    half();
    chk("full_pop_deq",   64'(deq),      64'(1));
    chk("full_no_bypass", 64'(in_ready), 64'(0));
    fin();
    doRetire = 1'b0;
    half();
    chk("ready_after_deq", 64'(in_ready), 64'(1));
    fin();
    in_valid = 1'b0;

    // mismatched II and stall block retire; then drain back to back
    doRetire = 1'b1; cntrl_II = sb[0].ii + 6'd1;
    repeat (2) begin
      half(); chk("mismatch_no_deq", 64'(deq), 64'(0)); fin();
    end
    bStall = 1'b1; cntrl_II = sb[0].ii;
    repeat (2) begin
      half(); chk("stall_no_deq", 64'(deq), 64'(0)); fin();
    end
    bStall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (sb.size() > 0) cntrl_II = sb[0].ii;
      half(); chk("b2b_deq", 64'(deq), 64'(1)); fin();
    end
    doRetire = 1'b0;
    step();
    chk("b2b_empty", 64'(sb.size()), 64'(0));

    // interleaved threads, flush thread 0
    for (int i = 0; i < 4; i++) begin
      rand_bundle(); in_thread = 1'(i % 2); in_II = IW'(30 + i); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    except = 1'b1; except_thread = 1'b0;
    step();
    except = 1'b0;
    half();
    chk("killed_head_hidden", 64'(out_valid), 64'(0));
    fin();
    chk("flush_survivors", 64'(sb.size()), 64'(2));
    drain(12, "flush_drain");

    // lane1 exception on slot 9
    clear_bundle();
    in_valid = 1'b1; in_II = 6'd40;
    set_lane(1, 9, 1'b1, 1'b0, 1'b0, 4'hA);
    step();
    clear_bundle();
    doRetire = 1'b1; cntrl_II = 6'd40;
    step();
    doRetire = 1'b0;
    half();
    chk("exc9_except", 64'(retire_except[9]),       64'(1));
    chk("exc9_exbits", 64'(retire_exbits[39:36]),   64'(4'hA));
    chk("exc9_fine",   64'(retire_fine[9]),         64'(0));
    fin();

    // two lanes on slot 2
    clear_bundle();
    in_valid = 1'b1; in_II = 6'd41;
    set_lane(0, 2, 1'b0, 1'b0, 1'b0, 4'h1);
    set_lane(4, 2, 1'b0, 1'b0, 1'b0, 4'h2);
    step();
    clear_bundle();
    doRetire = 1'b1; cntrl_II = 6'd41;
    step();
    doRetire = 1'b0;
    half();
    chk("dup_flag",   64'(dup_err),          64'(DUP_ON));
    chk("dup_except", 64'(retire_except[2]), 64'(DUP_ON));
    chk("dup_en",     64'(retire_enOut),     64'(10'h004));
    fin();

    // randomised traffic
    for (int c = 0; c < 400; c++) begin
      rand_bundle();
      in_valid = ($urandom_range(0, 9) < 6);
      doRetire = ($urandom_range(0, 3) != 0);
      bStall   = ($urandom_range(0, 9) == 0);
      if (sb.size() > 0 && $urandom_range(0, 4) != 0) cntrl_II = sb[0].ii;
      else cntrl_II = IW'($urandom);
      except        = ($urandom_range(0, 19) == 0);
      except_thread = 1'($urandom);
      step();
    end
    drain(60, "random_drain");

    // reset while a retire is pending
    for (int i = 0; i < 2; i++) begin
      rand_bundle(); in_valid = 1'b1; in_II = IW'(50 + i);
      step();
    end
    clear_bundle();
    doRetire = 1'b1; cntrl_II = sb[0].ii;
    #2 rst = 1'b0;
    sb.delete();
    exp_dup = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    doRetire = 1'b0;
    half();
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_ready",  64'(in_ready),  64'(1));
    chk("mid_rst_en",        64'(retire_enOut), 64'(0));
    chk("mid_rst_dup",       64'(dup_err),   64'(0));
    fin();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
